// File: rtl/ccc_lock_seq.sv
// Fabric reset sequencer and PLL lock supervisor for the CCC fabric clock domain.
// Optional lock timeout flag is compiled in with `define CCC_LOCK_TIMEOUT_EN.
module ccc_lock_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             FAB_LOCK,
  input  logic             MSS_LOCK,
  input  logic             MSS_LOCK_MASK,
  input  logic             SW_RST,
  input  logic             CLR_STATUS,
  output logic             FAB_RST_OUT,
  output logic             CLK_READY,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] LOSS_CNT,
  output logic             LOCK_TIMEOUT
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      CNT_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ccc_lock_seq: illegal parameter value");
  end

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD, RUN} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   loss;
  logic [SYNC_STAGES-1:0] fab_sync;
  logic [SYNC_STAGES-1:0] mss_sync;
  logic                   lock_s;

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      fab_sync <= '0;
      mss_sync <= '0;
    end else begin
      fab_sync <= {fab_sync[SYNC_STAGES-2:0], FAB_LOCK};
      mss_sync <= {mss_sync[SYNC_STAGES-2:0], MSS_LOCK};
    end
  end

  assign lock_s = fab_sync[SYNC_STAGES-1] & (mss_sync[SYNC_STAGES-1] | MSS_LOCK_MASK);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = QUALIFY;
          cnt_nxt   = '0;
        end
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // Lock loss takes priority over a software re-run request.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss      = 1'b1;
        end else if (SW_RST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      FAB_RST_OUT <= 1'b1;
      CLK_READY   <= 1'b0;
      LOCK_LOST   <= 1'b0;
      LOSS_CNT    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      FAB_RST_OUT <= (state_nxt != RUN);
      CLK_READY   <= (state_nxt == RUN);
      if (loss) begin
        LOCK_LOST <= 1'b1;
      end else if (CLR_STATUS) begin
        LOCK_LOST <= 1'b0;
      end
      if (loss && (LOSS_CNT != '1)) begin
        LOSS_CNT <= LOSS_CNT + 1'b1;
      end
    end
  end

`ifdef CCC_LOCK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Counter freezes in HOLD so a software-requested hold cannot trip the flag.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt      <= '0;
      LOCK_TIMEOUT <= 1'b0;
    end else if (state == HOLD && state_nxt == RUN) begin
      tmo_cnt      <= '0;
      LOCK_TIMEOUT <= 1'b0;
    end else if (state == WAIT_LOCK || state == QUALIFY) begin
      if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        LOCK_TIMEOUT <= 1'b1;
      end
    end
  end
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/ccc_lock_seq.md
# ccc_lock_seq

Fabric reset sequencer and lock supervisor for the MSS clock conditioning circuit (CCC). Clocked by the CCC-generated fabric clock, it synchronizes the PLL lock indications and qualifies lock as stable for a programmable interval. It then holds fabric reset for a further interval before releasing it. It re-asserts reset immediately on loss of lock and keeps sticky, CPU-readable lock-loss status and a lock-loss counter.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for FAB_LOCK/MSS_LOCK; legal 2..4.
- STABLE_CYCLES, 1024: consecutive locked cycles required before hold phase; legal >=1.
- HOLD_CYCLES, 16: cycles reset stays asserted after qualification; legal >=1.
- CNT_W, 8: width of lock-loss counter.
- TIMEOUT_CYCLES, 65536: lock timeout threshold (used only with CCC_LOCK_TIMEOUT_EN).

Ports:
- FAB_CLK  input  1  fabric clock (CCC GLB output); all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FAB_LOCK  input  1  PLL fabric lock, asynchronous to FAB_CLK.
- MSS_LOCK  input  1  PLL MSS lock, asynchronous to FAB_CLK.
- MSS_LOCK_MASK  input  1  1 = ignore MSS_LOCK (lock = FAB_LOCK only); quasi-static.
- SW_RST  input  1  single-cycle synchronous request to re-run reset hold.
- CLR_STATUS  input  1  single-cycle synchronous clear of LOCK_LOST.
- FAB_RST_OUT  output  1  registered active-high reset to fabric logic.
- CLK_READY  output  1  registered; 1 only in RUN.
- LOCK_LOST  output  1  sticky; set on lock loss in RUN.
- LOSS_CNT  output  CNT_W  saturating count of lock losses in RUN.
- LOCK_TIMEOUT  output  1  sticky timeout flag; constant 0 when feature compiled out.

## Operation
- lock_s = sync(FAB_LOCK) & (sync(MSS_LOCK) | MSS_LOCK_MASK); each input has its own SYNC_STAGES flop chain.
- Reset values: state WAIT_LOCK, FAB_RST_OUT=1, CLK_READY=0, LOCK_LOST=0, LOSS_CNT=0, LOCK_TIMEOUT=0, all counters 0, synchronizer flops 0.
- WAIT_LOCK: FAB_RST_OUT=1. If lock_s=1, go to QUALIFY and clear cnt.
- QUALIFY: FAB_RST_OUT=1.
  - lock_s=0: go to WAIT_LOCK; glitch, not counted in LOSS_CNT.
  - cnt==STABLE_CYCLES-1: go to HOLD and clear cnt.
  - Otherwise cnt++.
- HOLD: FAB_RST_OUT=1.
  - lock_s=0: go to WAIT_LOCK.
  - cnt==HOLD_CYCLES-1: go to RUN.
  - Otherwise cnt++.
- RUN: FAB_RST_OUT=0, CLK_READY=1.
  - lock_s=0: go to WAIT_LOCK, set LOCK_LOST, LOSS_CNT++ (saturates at all-ones).
  - Else SW_RST=1: go to HOLD, clear cnt. Lock is not requalified; no status change.
- Lock loss has priority over SW_RST when both occur in the same cycle.
- SW_RST outside RUN is ignored.
- LOCK_LOST set and CLR_STATUS in the same cycle: set wins.
- CLR_STATUS does not clear LOSS_CNT; only RESET clears it.
- Outputs are registered and decoded from next state, so they change in the first cycle of the new state.
- RESET asserted mid-sequence: immediately returns to reset values (FAB_RST_OUT=1 asynchronously). Deassertion restarts from WAIT_LOCK.

## Timing
- Lock-sensitive states are QUALIFY, HOLD and RUN. Lock input to lock_s: SYNC_STAGES cycles.
- FAB_LOCK rise (lock already otherwise met) to FAB_RST_OUT fall: SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES cycles, given stable lock.
- FAB_LOCK fall in RUN to FAB_RST_OUT rise: SYNC_STAGES + 1 cycles. LOCK_LOST and LOSS_CNT update in the same cycle.
- SW_RST in RUN: FAB_RST_OUT=1 next cycle, low again HOLD_CYCLES cycles later.
- Lock pulses shorter than the synchronizer resolution may be missed; this is acceptable.

## Configuration
- Macro: CCC_LOCK_TIMEOUT_EN.
- Defined:
  - A timeout counter counts every cycle in WAIT_LOCK and QUALIFY, saturating at TIMEOUT_CYCLES.
  - LOCK_TIMEOUT sets when the count reaches TIMEOUT_CYCLES-1.
  - Counter and flag clear on entry to RUN or on RESET.
  - The counter holds during HOLD.
- Not defined: no counter; LOCK_TIMEOUT tied to 0. All other behaviour is identical.

## Test plan
Test parameters: SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2, TIMEOUT_CYCLES=32.
- Power-up, both locks raised together, mask=0 -> FAB_RST_OUT falls exactly 15 cycles after the sampled FAB_LOCK edge; CLK_READY=1 in the same cycle.
- FAB_LOCK glitch high for 5 cycles, then low, then stable high -> no release during the glitch, LOSS_CNT=0. Release 15 cycles after the final rise.
- In RUN, drop FAB_LOCK -> FAB_RST_OUT=1 after 3 cycles, LOCK_LOST=1, LOSS_CNT=1. Repeat 4 losses -> LOSS_CNT=3 (saturated). CLR_STATUS coincident with a loss -> LOCK_LOST stays 1.
- In RUN, pulse SW_RST -> FAB_RST_OUT high for 4 cycles, then low; LOSS_CNT unchanged. SW_RST coincident with lock_s falling -> WAIT_LOCK, LOSS_CNT increments.
- MSS_LOCK held 0, mask=1 -> releases on FAB_LOCK alone. Mask=0 -> stays in WAIT_LOCK.
- With CCC_LOCK_TIMEOUT_EN, no lock -> LOCK_TIMEOUT=1 after 32 cycles; clears on reaching RUN. Without the macro -> LOCK_TIMEOUT=0 throughout.
- Assert RESET during HOLD -> FAB_RST_OUT=1 and CLK_READY=0 asynchronously. After deassertion, a full requalification is required.
